kbd_matrix_scanner: RTL and testbench

- Upstream stage of the 4-bit output register.
- Scans a 4x4 active-low key matrix, debounces the key press and encodes it to a 4-bit code on kbd1..kbd4.
- Pulses LoadOut for exactly one MainClock cycle per accepted press; the output register latches the code on that pulse.
- Holds the code stable between presses. Enforces release-before-next-key.

---
 rtl/kbd_pkg.sv | 33 +++
 rtl/kbd_sync.sv | 29 ++
 rtl/kbd_matrix_scanner.sv | 174 +++++++++++++++++
 tb/tb_kbd_matrix_scanner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and helpers for the 4x4 key matrix scanner: matrix geometry,
// scanner state encoding, and the row/column to key-code mapping.
package kbd_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int COL_W    = $clog2(NUM_COLS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } kbd_state_e;

  function automatic logic [CODE_W-1:0] kbd_encode(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return CODE_W'(int'(row) * NUM_COLS + int'(col));
  endfunction

  // Lowest-index active-low row; callers qualify with "any row low".
  function automatic logic [ROW_W-1:0] kbd_first_low(input logic [NUM_ROWS-1:0] r);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!r[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kbd_sync.sv
// Two-flop synchronizer for the asynchronous matrix row lines; clears to all
// ones so an idle (pulled-up) matrix reads as "no key" straight out of reset.
module kbd_sync
  import kbd_pkg::*;
#(
  parameter int W = NUM_ROWS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/kbd_matrix_scanner.sv
// 4x4 active-low key matrix scanner with debounce, key encoding and a one-cycle
// LoadOut strobe. Define KBD_REPEAT_EN to re-strobe every REPEAT_CYCLES while held.
module kbd_matrix_scanner
  import kbd_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic                MainClock,
  input  logic                invMainReset,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic                kbd1,
  output logic                kbd2,
  output logic                kbd3,
  output logic                kbd4,
  output logic                LoadOut
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (SCAN_DIV < 3) begin : g_bad_scan_div
      $error("kbd_matrix_scanner: SCAN_DIV must be at least 3");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("kbd_matrix_scanner: DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("kbd_matrix_scanner: REPEAT_CYCLES must be at least 2");
    end
  endgenerate

  logic [NUM_ROWS-1:0] rs;

  kbd_sync #(.W(NUM_ROWS)) u_sync (
    .clk   (MainClock),
    .rst_n (invMainReset),
    .d     (rows),
    .q     (rs)
  );

  kbd_state_e          state_q, state_d;
  logic [COL_W-1:0]    col_q,   col_d;
  logic [ROW_W-1:0]    row_q,   row_d;
  logic [DIV_W-1:0]    div_q,   div_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [CODE_W-1:0]   kbd_q,   kbd_d;
  logic                load_q,  load_d;
`ifdef KBD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0]    rep_q,   rep_d;
`endif

  logic any_low;
  logic row_match;

  // A sample matches only if the captured row is the lowest active row.
  assign any_low   = ~&rs;
  assign row_match = any_low && (kbd_first_low(rs) == row_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    kbd_d   = kbd_q;
    load_d  = 1'b0;
`ifdef KBD_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (any_low) begin
            row_d   = kbd_first_low(rs);
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (row_match) begin
          if (cnt_q == DEB_LAST) state_d = EMIT;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = SCAN;
          col_d   = col_q + COL_W'(1);
          div_d   = '0;
        end
      end
      EMIT: begin
        kbd_d   = kbd_encode(row_q, col_q);
        load_d  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_RELEASE;
`ifdef KBD_REPEAT_EN
        rep_d   = '0;
`endif
      end
      WAIT_RELEASE: begin
        if (&rs) begin
          if (cnt_q == DEB_LAST) begin
            state_d = SCAN;
            col_d   = col_q + COL_W'(1);
            div_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
`ifdef KBD_REPEAT_EN
        if (!rs[row_q]) begin
          if (rep_q == REP_LAST) begin
            rep_d  = '0;
            load_d = 1'b1;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end else begin
          rep_d = '0;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge MainClock or negedge invMainReset) begin
    if (!invMainReset) begin
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      kbd_q   <= '0;
      load_q  <= 1'b0;
`ifdef KBD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      kbd_q   <= kbd_d;
      load_q  <= load_d;
`ifdef KBD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign cols    = ~(NUM_COLS'(1) << col_q);
  assign kbd1    = kbd_q[0];
  assign kbd2    = kbd_q[1];
  assign kbd3    = kbd_q[2];
  assign kbd4    = kbd_q[3];
  assign LoadOut = load_q;

endmodule

// File: tb/tb_kbd_matrix_scanner.sv
// Directed bench for kbd_matrix_scanner: a behavioural key matrix drives the
// rows from the scanned column; expected codes and timings are hand-derived.
module tb_kbd_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       kbd1, kbd2, kbd3, kbd4;
  logic       load;

  always #5 clk = ~clk;

  kbd_matrix_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (64)
  ) dut (
    .MainClock    (clk),
    .invMainReset (rst_n),
    .rows         (rows),
    .cols         (cols),
    .kbd1         (kbd1),
    .kbd2         (kbd2),
    .kbd3         (kbd3),
    .kbd4         (kbd4),
    .LoadOut      (load)
  );

  // key[r*4+c] closes the switch between row r and column c.
  logic [15:0] key;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  int load_cnt = 0;
  bit prev_load = 1'b0;
  bit dbl_load = 1'b0;

  always @(negedge clk) begin
    if (load) begin
      load_cnt <= load_cnt + 1;
      if (prev_load) dbl_load <= 1'b1;
    end
    prev_load <= load;
  end

  int errors = 0;
  int checks = 0;

  function automatic logic [3:0] code();
    return {kbd4, kbd3, kbd2, kbd1};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_load(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (load) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_cols(input logic [3:0] target, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (cols == target) begin
        cyc = i;
        break;
      end
    end
  endtask

  typedef struct {
    int         row;
    int         col;
    logic [3:0] exp_code;
    logic [3:0] hold_cols;
    logic [3:0] next_cols;
  } vec_t;

  vec_t tbl[4];
  logic [3:0] scan_pat[4];

`ifdef KBD_REPEAT_EN
  localparam int HOLD_STROBES = 4;
`else
  localparam int HOLD_STROBES = 1;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n0;

    tbl[0] = '{row: 2, col: 1, exp_code: 4'b1001, hold_cols: 4'b1101, next_cols: 4'b1011};
    tbl[1] = '{row: 1, col: 2, exp_code: 4'b0110, hold_cols: 4'b1011, next_cols: 4'b0111};
    tbl[2] = '{row: 3, col: 0, exp_code: 4'b1100, hold_cols: 4'b1110, next_cols: 4'b1101};
    tbl[3] = '{row: 0, col: 0, exp_code: 4'b0000, hold_cols: 4'b1110, next_cols: 4'b1101};
    scan_pat[0] = 4'b1110;
    scan_pat[1] = 4'b1101;
    scan_pat[2] = 4'b1011;
    scan_pat[3] = 4'b0111;

    rst_n = 1'b0;
    key   = '0;
    tick(3);
    check("reset_cols", cols, 4'b1110);
    check("reset_kbd", code(), 4'b0000);
    check("reset_load", load, 1'b0);

    // Idle scan: each column stays driven for four cycles.
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) tick(1);
      check($sformatf("idle_cols_%0d", i), cols, scan_pat[(i / 4) % 4]);
    end
    check("idle_no_load", load_cnt, 0);
    check("idle_kbd", code(), 4'b0000);

    // Single clean presses from the table.
    for (int t = 0; t < 4; t++) begin
      n0 = load_cnt;
      key[tbl[t].row*4 + tbl[t].col] = 1'b1;
      wait_load(40, cyc);
      check($sformatf("tbl%0d_latency_ok", t), (cyc > 0 && cyc <= 23), 1);
      check($sformatf("tbl%0d_code", t), code(), tbl[t].exp_code);
      check($sformatf("tbl%0d_frozen_cols", t), cols, tbl[t].hold_cols);
      key = '0;
      wait_cols(tbl[t].next_cols, 30, cyc);
      check($sformatf("tbl%0d_release_cycles", t), cyc, 6);
      check($sformatf("tbl%0d_kbd_held", t), code(), tbl[t].exp_code);
      check($sformatf("tbl%0d_one_strobe", t), load_cnt - n0, 1);
    end

    // Row0/col3 bouncing with single-cycle glitches, then stable.
    n0 = load_cnt;
    for (int i = 0; i < 48; i++) begin
      key[3] = (i % 2 == 0);
      tick(1);
    end
    check("bounce_no_load", load_cnt - n0, 0);
    key[3] = 1'b1;
    wait_load(40, cyc);
    check("bounce_stable_seen", (cyc > 0), 1);
    check("bounce_code", code(), 4'b0011);
    key = '0;
    tick(30);
    check("bounce_one_strobe", load_cnt - n0, 1);

    // Rows 1 and 3 in col0 together; row1 wins. Col2 key while held is ignored.
    wait_cols(4'b1101, 30, cyc);
    n0 = load_cnt;
    key[4]  = 1'b1;
    key[12] = 1'b1;
    wait_load(40, cyc);
    check("multi_seen", (cyc > 0), 1);
    check("multi_code", code(), 4'b0100);
    key[2] = 1'b1;
    tick(30);
    check("multi_other_col_ignored", load_cnt - n0, 1);
    check("multi_cols_frozen", cols, 4'b1110);
    key = '0;
    tick(30);
    check("multi_after_release", load_cnt - n0, 1);
    check("multi_kbd_held", code(), 4'b0100);

    // Reset in the middle of debouncing row3/col3.
    wait_cols(4'b1110, 30, cyc);
    n0 = load_cnt;
    key[15] = 1'b1;
    wait_cols(4'b0111, 30, cyc);
    tick(5);
    check("mid_reset_no_load_yet", load_cnt - n0, 0);
    rst_n = 1'b0;
    #1;
    check("mid_reset_cols", cols, 4'b1110);
    check("mid_reset_kbd", code(), 4'b0000);
    check("mid_reset_load", load, 1'b0);
    key = '0;
    tick(3);
    rst_n = 1'b1;
    tick(60);
    check("after_reset_no_load", load_cnt - n0, 0);

    // Re-press and hold for a long time.
    key[15] = 1'b1;
    wait_load(40, cyc);
    check("repress_seen", (cyc > 0), 1);
    check("repress_code", code(), 4'b1111);
    tick(200);
    check("hold_strobes", load_cnt - n0, HOLD_STROBES);
    check("hold_code", code(), 4'b1111);
    key = '0;
    tick(30);
    check("hold_release_strobes", load_cnt - n0, HOLD_STROBES);
    check("never_back_to_back", dbl_load, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
